// File: rtl/alu32_reg.sv
// alu32_reg: 32-bit integer ALU for the execute stage with registered outputs.
// R/C/O/Z load the combinational result when en=1 and hold otherwise;
// reset clears them (R=0, Z=1) and has priority over en.
// Optional macro ALU_MULT_EN: when defined, opcode 0xC is MUL (low 32 bits of
// A*B, O set when the unsigned 64-bit product overflows 32 bits). When it is
// undefined, 0xC is reserved and no multiplier is built.
module alu32_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Alu_Op,
  output logic             C,
  output logic             O,
  output logic             Z,
  output logic [WIDTH-1:0] R
);

  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_XOR  = 4'h2;
  localparam logic [3:0] OP_NOR  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_SLT  = 4'h6;
  localparam logic [3:0] OP_SLTU = 4'h7;
  localparam logic [3:0] OP_SLL  = 4'h8;
  localparam logic [3:0] OP_SRL  = 4'h9;
  localparam logic [3:0] OP_SRA  = 4'hA;
  localparam logic [3:0] OP_LUI  = 4'hB;
`ifdef ALU_MULT_EN
  localparam logic [3:0] OP_MUL  = 4'hC;
`endif

  logic [WIDTH-1:0] r_q, r_d;
  logic             c_q, c_d;
  logic             o_q, o_d;
  logic             z_q, z_d;

  // Shared adder paths; the bit above the MSB is the carry out.
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [4:0]       shamt;
  logic             slt_w;
  logic             sltu_w;

  assign sum_w  = {1'b0, A} + {1'b0, B};
  // Subtraction as A + ~B + 1 so the carry out means "no borrow" (A >= B).
  assign diff_w = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
  assign shamt  = A[4:0];
  assign slt_w  = $signed(A) < $signed(B);
  assign sltu_w = A < B;

`ifdef ALU_MULT_EN
  logic [2*WIDTH-1:0] prod_w;
  // Zero-extended operands: the low half is sign-agnostic, the high half
  // is the unsigned overflow indicator.
  assign prod_w = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
`endif

  // Next-state result and flags from the current opcode and operands.
  always_comb begin
    r_d = '0;
    c_d = 1'b0;
    o_d = 1'b0;
    case (Alu_Op)
      OP_AND:  r_d = A & B;
      OP_OR:   r_d = A | B;
      OP_XOR:  r_d = A ^ B;
      OP_NOR:  r_d = ~(A | B);
      OP_ADD: begin
        r_d = sum_w[WIDTH-1:0];
        c_d = sum_w[WIDTH];
        o_d = (A[WIDTH-1] == B[WIDTH-1]) && (sum_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        r_d = diff_w[WIDTH-1:0];
        c_d = diff_w[WIDTH];
        o_d = (A[WIDTH-1] != B[WIDTH-1]) && (diff_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT:  r_d = {{(WIDTH-1){1'b0}}, slt_w};
      OP_SLTU: r_d = {{(WIDTH-1){1'b0}}, sltu_w};
      OP_SLL:  r_d = B << shamt;
      OP_SRL:  r_d = B >> shamt;
      OP_SRA:  r_d = $signed(B) >>> shamt;
      OP_LUI:  r_d = {B[15:0], {(WIDTH-16){1'b0}}};
`ifdef ALU_MULT_EN
      OP_MUL: begin
        r_d = prod_w[WIDTH-1:0];
        o_d = |prod_w[2*WIDTH-1:WIDTH];
      end
`endif
      default: r_d = '0;
    endcase
    z_d = (r_d == '0);
  end

  // Output registers: reset first, then capture on en, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
      c_q <= 1'b0;
      o_q <= 1'b0;
      z_q <= 1'b1;
    end else if (en) begin
      r_q <= r_d;
      c_q <= c_d;
      o_q <= o_d;
      z_q <= z_d;
    end
  end

  assign R = r_q;
  assign C = c_q;
  assign O = o_q;
  assign Z = z_q;

endmodule

// File: tb/tb_alu32_reg.sv
// Directed bench for alu32_reg: hand-computed vectors for every opcode,
// flag edges, enable hold, reset priority and the 0xC opcode in either build.
module tb_alu32_reg;

  logic        clk;
  logic        reset;
  logic        en;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  Alu_Op;
  logic        C;
  logic        O;
  logic        Z;
  logic [31:0] R;

  int n_checks;
  int n_fail;

  logic [31:0] exp_q[$];

  alu32_reg #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .A      (A),
    .B      (B),
    .Alu_Op (Alu_Op),
    .C      (C),
    .O      (O),
    .Z      (Z),
    .R      (R)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Compare all four registered outputs against expected values.
  task automatic expect_out(input string tag, input logic [31:0] r,
                            input logic c, input logic o, input logic z);
    check_eq({tag, ".R"}, R, r);
    check_eq({tag, ".C"}, {31'd0, C}, {31'd0, c});
    check_eq({tag, ".O"}, {31'd0, O}, {31'd0, o});
    check_eq({tag, ".Z"}, {31'd0, Z}, {31'd0, z});
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic drive(input logic rst, input logic e, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] op);
    reset  = rst;
    en     = e;
    A      = a;
    B      = b;
    Alu_Op = op;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; en = 1'b0; A = '0; B = '0; Alu_Op = 4'h0;

    // Reset state
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    expect_out("reset", 32'h0, 1'b0, 1'b0, 1'b1);

    // Opcode sweep 0x0-0x8 with A=0x0A, B=0x64
    exp_q.push_back(32'h0000_0000); // AND
    exp_q.push_back(32'h0000_006E); // OR
    exp_q.push_back(32'h0000_006E); // XOR
    exp_q.push_back(32'hFFFF_FF91); // NOR
    exp_q.push_back(32'h0000_006E); // ADD
    exp_q.push_back(32'hFFFF_FFA6); // SUB
    exp_q.push_back(32'h0000_0001); // SLT
    exp_q.push_back(32'h0000_0001); // SLTU
    exp_q.push_back(32'h0001_9000); // SLL
    for (int op = 0; op <= 8; op++) begin
      logic [31:0] e_r;
      drive(1'b0, 1'b1, 32'h0A, 32'h64, 4'(op));
      e_r = exp_q.pop_front();
      expect_out($sformatf("sweep_op%0d", op), e_r, 1'b0, 1'b0, e_r == 32'h0);
    end

    // ADD overflow and carry
    drive(1'b0, 1'b1, 32'h7FFF_FFFF, 32'h1, 4'h4);
    expect_out("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1, 4'h4);
    expect_out("add_carry", 32'h0, 1'b1, 1'b0, 1'b1);

    // SUB edges
    drive(1'b0, 1'b1, 32'h8000_0000, 32'h1, 4'h5);
    expect_out("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 32'h5, 32'h5, 4'h5);
    expect_out("sub_zero", 32'h0, 1'b1, 1'b0, 1'b1);

    // Shifts, including amount 0 and ignored upper A bits
    drive(1'b0, 1'b1, 32'h4, 32'h8000_0000, 4'hA);
    expect_out("sra", 32'hF800_0000, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 32'h4, 32'h8000_0000, 4'h9);
    expect_out("srl", 32'h0800_0000, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 32'hFFFF_FFE0, 32'h1234, 4'h8);
    expect_out("sll_amt0", 32'h0000_1234, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 32'h0000_0021, 32'h8000_0001, 4'h9);
    expect_out("srl_amt1", 32'h4000_0000, 1'b0, 1'b0, 1'b0);

    // LUI
    drive(1'b0, 1'b1, 32'h0, 32'h1234, 4'hB);
    expect_out("lui", 32'h1234_0000, 1'b0, 1'b0, 1'b0);

    // Signed vs unsigned compare
    drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1, 4'h6);
    expect_out("slt_neg", 32'h1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1, 4'h7);
    expect_out("sltu_big", 32'h0, 1'b0, 1'b0, 1'b1);

    // Enable hold
    drive(1'b0, 1'b1, 32'h0A, 32'h64, 4'h4);
    expect_out("hold_load", 32'h6E, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1, 4'h4);
    expect_out("hold_keep", 32'h6E, 1'b0, 1'b0, 1'b0);

    // Reset mid-stream with en=1 clears nonzero flags
    drive(1'b0, 1'b1, 32'h8000_0000, 32'h1, 4'h5);
    expect_out("pre_reset", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 32'h8000_0000, 32'h1, 4'h5);
    expect_out("reset_en", 32'h0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 32'h0A, 32'h64, 4'h1);
    expect_out("post_reset", 32'h6E, 1'b0, 1'b0, 1'b0);

    // Reserved opcodes
    drive(1'b0, 1'b1, 32'h0A, 32'h64, 4'hE);
    expect_out("rsv_e", 32'h0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 32'h0A, 32'h64, 4'hF);
    expect_out("rsv_f", 32'h0, 1'b0, 1'b0, 1'b1);

    // Opcode 0xC
`ifdef ALU_MULT_EN
    drive(1'b0, 1'b1, 32'h0001_0000, 32'h0001_0000, 4'hC);
    expect_out("mul_ovf", 32'h0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 32'h0000_0003, 32'hFFFF_FFFF, 4'hC);
    expect_out("mul_neg", 32'hFFFF_FFFD, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 32'h0000_1000, 32'h0000_0010, 4'hC);
    expect_out("mul_small", 32'h0001_0000, 1'b0, 1'b0, 1'b0);
`else
    drive(1'b0, 1'b1, 32'h0001_0000, 32'h0001_0000, 4'hC);
    expect_out("rsv_c", 32'h0, 1'b0, 1'b0, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu32_reg.md
Name: alu32_reg

Overview:
- 32-bit integer ALU for the MIPS processor execute stage.
- Computes a result R and flags C (carry), O (signed overflow) and Z (zero) from operands A and B, selected by the 4-bit opcode Alu_Op.
- Outputs are registered: one clock of latency, with a capture enable so the pipeline can stall.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is required to work; shift amount is always taken from A[4:0].

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  capture enable; when 1, outputs load the new result on this edge.
- A  input  32  operand A; also supplies the shift amount for shift ops.
- B  input  32  operand B; the shifted operand for shift ops.
- Alu_Op  input  4  operation select.
- C  output  1  carry/no-borrow flag, registered.
- O  output  1  signed overflow flag, registered.
- Z  output  1  zero flag, registered.
- R  output  32  result, registered.

Behaviour:
- Reset (reset=1 at a clk edge) has priority over en. It sets R=0, C=0, O=0, Z=1, so Z stays consistent with R.
- Capture: if reset=0 and en=1, R/C/O/Z load the combinational result of the current A, B and Alu_Op at the edge. Latency is exactly 1 cycle.
- Hold: if en=0, all outputs keep their previous values.
- Opcode map:
  - 0x0 AND: A&B.
  - 0x1 OR: A|B.
  - 0x2 XOR: A^B.
  - 0x3 NOR: ~(A|B).
  - 0x4 ADD: A+B.
  - 0x5 SUB: A-B, computed as A+~B+1.
  - 0x6 SLT: R=1 if signed A<signed B, else 0.
  - 0x7 SLTU: R=1 if unsigned A<unsigned B, else 0.
  - 0x8 SLL: B<<A[4:0].
  - 0x9 SRL: B>>A[4:0], zero fill.
  - 0xA SRA: B>>>A[4:0], sign fill.
  - 0xB LUI: {B[15:0],16'h0}.
  - 0xC: see Optional Feature.
  - 0xD-0xF: reserved; R=0.
- C flag:
  - ADD: carry out of bit 31.
  - SUB: carry out of A+~B+1, i.e. 1 iff A>=B unsigned.
  - All other ops: 0.
- O flag:
  - ADD: 1 iff A and B have the same sign and the result sign differs.
  - SUB: 1 iff A and B have different signs and the result sign differs from A.
  - All other ops: 0.
- Z flag: 1 iff the 32-bit R being loaded equals 0. Applies to every opcode, including reserved ones (reserved ops give Z=1).
- Arithmetic wraps modulo 2^32; no exception or trap output.
- A shift amount of 0 returns B unchanged. Only A[4:0] is used; A[31:5] are ignored.
- If opcode and operands change in the same cycle, only the values present at the capturing edge matter; no internal pipeline or history.
- reset asserted mid-stream clears outputs on that edge regardless of en. The first capture after reset deasserts uses the inputs present at that edge.

Optional Feature:
- Macro: ALU_MULT_EN.
- Defined: opcode 0xC = MUL, where R = low 32 bits of A*B (same for signed and unsigned). C=0, O=1 iff the full unsigned 64-bit product does not fit in 32 bits. Z follows R.
- Not defined: opcode 0xC is reserved, giving R=0, C=0, O=0, Z=1. No multiplier logic is synthesized.

Test Plan:
- Reset, then A=0x0A, B=0x64, en=1, sweep Alu_Op 0x0-0x8, one cycle each. One cycle later the outputs must be:
  - AND: R=0, Z=1.
  - OR: 0x6E.
  - XOR: 0x6E.
  - NOR: 0xFFFFFF91.
  - ADD: 0x6E, C=0, O=0.
  - SUB: 0xFFFFFFA6, C=0, O=0.
  - SLT: 1.
  - SLTU: 1.
  - SLL: 0x00019000.
- ADD overflow/carry:
  - 0x7FFFFFFF+0x1 -> R=0x80000000, O=1, C=0, Z=0.
  - 0xFFFFFFFF+0x1 -> R=0, C=1, O=0, Z=1.
- SUB edges:
  - 0x80000000-0x1 -> R=0x7FFFFFFF, O=1, C=1.
  - 5-5 -> R=0, Z=1, C=1.
- Shifts with B=0x80000000, A=4:
  - SRA -> 0xF8000000.
  - SRL -> 0x08000000.
- LUI with B=0x1234 -> 0x12340000.
- SLT vs SLTU with A=0xFFFFFFFF, B=1: SLT -> 1, SLTU -> 0.
- en/reset:
  - Load 0x6E, drop en, change inputs -> R stays 0x6E.
  - Assert reset with en=1 -> R=0, Z=1, C=0, O=0 on that edge.
- Reserved opcode 0xE -> R=0, Z=1.
- 0xC checked in both builds:
  - With ALU_MULT_EN: 0x10000*0x10000 -> R=0, O=1, Z=1.
  - Without ALU_MULT_EN: R=0, Z=1, C=0, O=0.
